// File: rtl/ram512_arbiter_if.sv
// ============================================================================
// Module      : ram512_arbiter_if
// Description : Bus bundle between two requesters, the ram512_arbiter and the
//               ram512 macro. The arbiter uses the slave modport. The master
//               modport is the requester/RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram512_arbiter_if;
  // requester port 0 (CPU)
  logic        req0;
  logic        we0;
  logic [8:0]  addr0;
  logic [15:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic [15:0] rdata0;
  // requester port 1 (I/O)
  logic        req1;
  logic        we1;
  logic [8:0]  addr1;
  logic [15:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [15:0] rdata1;
  // ram512 side
  logic [8:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_out,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_address, ram_in, ram_load
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_out,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_address, ram_in, ram_load
  );
endinterface

`default_nettype wire

// File: rtl/ram512_arbiter.sv
// ============================================================================
// Module      : ram512_arbiter
// Description : Two-port arbiter in front of a single-port ram512. Each access
//               takes an IDLE cycle, where the winner is picked, and a SERVE
//               cycle, where the owner drives the RAM. Reads are registered per
//               port.
//               Macro RAM_ARB_RR_EN: when defined, ties go round robin. When
//               undefined, port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram512_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  ram512_arbiter_if.slave  bus
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SERVE = 1'b1;

  logic [0:0]  r_state;
  logic        r_owner;
  logic        w_any_req;
  logic        w_winner;
  logic        w_serve;
  logic        w_owner_we;

  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic [8:0]  w_ram_address;
  logic [15:0] w_ram_in;
  logic        w_ram_load;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_serve   = (r_state == c_SERVE);

`ifdef RAM_ARB_RR_EN
  logic r_last;

  // Tie goes to the port that was not served last. A lone requester always wins.
  always_comb begin
    w_winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      w_winner = ~r_last;
    end
  end

  // Remember the port that got the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == c_IDLE && w_any_req) begin
      r_last <= w_winner;
    end
  end
`else
  // Fixed priority. Port 1 wins only when port 0 is not requesting.
  always_comb begin
    w_winner = bus.req1 & ~bus.req0;
  end
`endif

  // Two-state sequencer. Latch the winner in IDLE, and always leave SERVE after one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_state <= c_SERVE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign w_owner_we = r_owner ? bus.we1 : bus.we0;

  // RAM drive and grant are decoded from the state and owner only. An async reset of the state therefore drops them at once.
  always_comb begin
    w_gnt0        = 1'b0;
    w_gnt1        = 1'b0;
    w_ram_address = 9'd0;
    w_ram_in      = 16'd0;
    w_ram_load    = 1'b0;
    if (w_serve) begin
      w_ram_load = w_owner_we;
      if (r_owner) begin
        w_gnt1        = 1'b1;
        w_ram_address = bus.addr1;
        w_ram_in      = bus.wdata1;
      end else begin
        w_gnt0        = 1'b1;
        w_ram_address = bus.addr0;
        w_ram_in      = bus.wdata0;
      end
    end
  end

  // Capture read data into the owner's register at the edge that ends SERVE. rvalid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 16'd0;
      r_rdata1  <= 16'd0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_serve && !w_owner_we) begin
        if (r_owner) begin
          r_rdata1  <= bus.ram_out;
          r_rvalid1 <= 1'b1;
        end else begin
          r_rdata0  <= bus.ram_out;
          r_rvalid0 <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt0        = w_gnt0;
  assign bus.gnt1        = w_gnt1;
  assign bus.ram_address = w_ram_address;
  assign bus.ram_in      = w_ram_in;
  assign bus.ram_load    = w_ram_load;
  assign bus.rvalid0     = r_rvalid0;
  assign bus.rvalid1     = r_rvalid1;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_ram512_arbiter.sv
// ============================================================================
// Module      : tb_ram512_arbiter
// Description : Self-checking bench for ram512_arbiter with a behavioural
//               ram512 model. It uses a table of single accesses plus
//               hand-written sequences for contention and for reset in the
//               middle of SERVE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram512_arbiter;

  logic clk;
  logic rst_n;

  ram512_arbiter_if bus ();

  ram512_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural ram512: combinational read, clocked write
  logic [15:0] mem [512];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.ram_load) begin
      mem[bus.ram_address] <= bus.ram_in;
    end
  end
  assign bus.ram_out = mem[bus.ram_address];

  // ---------------- bookkeeping
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- access table
  typedef struct {
    bit          port;
    bit          we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];
  logic [15:0] model_rdata [2];

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    @(posedge clk) #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk) #1;
    pl_en = 1'b0;
  endtask

  task automatic set_req(input bit port, input bit v, input bit we,
                         input logic [8:0] a, input logic [15:0] d);
    if (port) begin
      bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  // One uncontested access, checked for latency, RAM drive, rvalid and rdata.
  task automatic run_access(input vec_t v, input int idx);
    int  waited;
    bit  got;
    logic g_own, g_oth, rv_own, rv_oth;
    logic [15:0] rd_own, rd_oth;
    got = 1'b0;
    waited = 0;
    @(posedge clk) #1;
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (!got && waited < 8) begin
      @(negedge clk);
      waited++;
      g_own = v.port ? bus.gnt1 : bus.gnt0;
      if (g_own) got = 1'b1;
    end
    if (!got) begin
      chk($sformatf("v%0d_gnt_timeout", idx), 32'(got), 32'd1);
    end else begin
      g_oth = v.port ? bus.gnt0 : bus.gnt1;
      chk($sformatf("v%0d_gnt_latency", idx), 32'(waited), 32'd2);
      chk($sformatf("v%0d_other_gnt", idx), 32'(g_oth), 32'd0);
      chk($sformatf("v%0d_ram_address", idx), 32'(bus.ram_address), 32'(v.addr));
      chk($sformatf("v%0d_ram_load", idx), 32'(bus.ram_load), 32'(v.we));
      if (v.we) chk($sformatf("v%0d_ram_in", idx), 32'(bus.ram_in), 32'(v.wdata));
    end
    @(posedge clk) #1;
    set_req(v.port, 1'b0, 1'b0, 9'd0, 16'd0);
    @(negedge clk);
    rv_own = v.port ? bus.rvalid1 : bus.rvalid0;
    rv_oth = v.port ? bus.rvalid0 : bus.rvalid1;
    rd_own = v.port ? bus.rdata1 : bus.rdata0;
    rd_oth = v.port ? bus.rdata0 : bus.rdata1;
    if (!v.we) model_rdata[v.port] = v.exp_rdata;
    chk($sformatf("v%0d_rvalid", idx), 32'(rv_own), 32'(!v.we));
    chk($sformatf("v%0d_other_rvalid", idx), 32'(rv_oth), 32'd0);
    chk($sformatf("v%0d_rdata", idx), 32'(rd_own), 32'(model_rdata[v.port]));
    chk($sformatf("v%0d_other_rdata_hold", idx), 32'(rd_oth), 32'(model_rdata[!v.port]));
    @(negedge clk);
    chk($sformatf("v%0d_rvalid_one_cycle", idx), 32'(rv_own & (v.port ? bus.rvalid1 : bus.rvalid0)), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int  gseq [$];
  int  exp_seq [4];
  logic [15:0] rd;

  initial begin
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 16'd0);
    model_rdata[0] = 16'd0;
    model_rdata[1] = 16'd0;

    // Preload the RAM while the arbiter is held in reset.
    preload(9'h000, 16'h5555);
    preload(9'h100, 16'hC0DE);
    preload(9'h1FF, 16'h0000);
    preload(9'h040, 16'h0000);

    vecs[0] = '{1'b0, 1'b1, 9'h1FF, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 9'h1FF, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 9'h040, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 9'h040, 16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h5555};
    vecs[5] = '{1'b1, 1'b0, 9'h100, 16'h0000, 16'hC0DE};
    vecs[6] = '{1'b0, 1'b0, 9'h100, 16'h0000, 16'hC0DE};

    // Reset values
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
    chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
    chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
    chk("rst_ram_load", 32'(bus.ram_load), 32'd0);
    chk("rst_ram_address", 32'(bus.ram_address), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_access(vecs[i], i);
    end

    // Contention: both ports read continuously for 8 cycles right after reset.
    do_reset();
    model_rdata[0] = 16'd0;
    model_rdata[1] = 16'd0;
    @(posedge clk) #1;
    set_req(1'b0, 1'b1, 1'b0, 9'h000, 16'd0);
    set_req(1'b1, 1'b1, 1'b0, 9'h100, 16'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) gseq.push_back(2);
      else if (bus.gnt0)        gseq.push_back(0);
      else if (bus.gnt1)        gseq.push_back(1);
    end
    @(posedge clk) #1;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    set_req(1'b1, 1'b0, 1'b0, 9'd0, 16'd0);
`ifdef RAM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    chk("tie_grant_count", 32'(gseq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gseq.size()) chk($sformatf("tie_grant_%0d", k), 32'(gseq[k]), 32'(exp_seq[k]));
    end
    @(negedge clk);
    chk("tie_rdata0", 32'(bus.rdata0), 32'h5555);
`ifdef RAM_ARB_RR_EN
    chk("tie_rdata1", 32'(bus.rdata1), 32'hC0DE);
`else
    chk("tie_rdata1", 32'(bus.rdata1), 32'h0000);
`endif

    // Reset in the middle of a SERVE write: the write must not commit.
    do_reset();
    @(posedge clk) #1;
    set_req(1'b0, 1'b1, 1'b1, 9'h000, 16'hAAAA);
    @(negedge clk);
    @(negedge clk);
    chk("mid_gnt0", 32'(bus.gnt0), 32'd1);
    chk("mid_ram_load_before", 32'(bus.ram_load), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_ram_load_after", 32'(bus.ram_load), 32'd0);
    chk("mid_gnt0_after", 32'(bus.gnt0), 32'd0);
    @(posedge clk) #1;
    set_req(1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    @(negedge clk);
    chk("mid_rvalid0", 32'(bus.rvalid0), 32'd0);
    rst_n = 1'b1;
    model_rdata[0] = 16'd0;
    model_rdata[1] = 16'd0;
    run_access('{1'b0, 1'b0, 9'h000, 16'h0000, 16'h5555}, 7);
    rd = bus.rdata0;
    repeat (3) @(negedge clk);
    chk("rdata0_hold", 32'(bus.rdata0), 32'(rd));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog, so a stuck run still reaches the summary line.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
